alu_seq_unit: RTL and testbench

Parametrised WIDTH-bit ALU with a registered result, a valid/ready handshake on both sides, and an iterative unsigned shift-add multiplier. It replaces the bit-sliced combinational ALU chain in the CPU execute stage. Single-cycle ops return one cycle after acceptance. MUL takes WIDTH+1 cycles, so the unit can stall the pipeline.

---
 rtl/alu_seq_unit_pkg.sv | 19 +
 rtl/alu_seq_unit_if.sv | 28 ++
 rtl/alu_seq_unit_comb.sv | 44 ++++
 rtl/alu_seq_unit.sv | 106 ++++++++++
 tb/tb_alu_seq_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
// Operation codes are {invertA, invertB, op[1:0]}.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_MULU = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle of the sequential ALU.
// The unit itself is the slave; the pipeline stage feeding it is the master.
interface alu_seq_unit_if #(
   parameter int WIDTH = 32
);

   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic [3:0]       ctrl_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             overflow_o;

   modport master (
      output in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, zero_o, overflow_o
   );

   modport slave (
      input  in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, zero_o, overflow_o
   );

endinterface

// File: rtl/alu_seq_unit_comb.sv
// Combinational datapath for the single-cycle ops. SLT is delivered through
// 'set' and MULU is handled by the sequencer, so both yield result 0 here.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctrl,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             set
);

   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             c_msb;
   logic             c_out;

   always_comb begin
      a_eff = ctrl[3] ? ~a : a;
      b_eff = ctrl[2] ? ~b : b;
      // Split the adder at the MSB so both carries needed for overflow are visible.
      {c_msb, sum[WIDTH-2:0]} = {1'b0, a_eff[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                                + {{(WIDTH-1){1'b0}}, ctrl[2]};
      {c_out, sum[WIDTH-1]}   = {1'b0, a_eff[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, c_msb};
      set      = sum[WIDTH-1] ^ (c_msb ^ c_out);
      result   = '0;
      overflow = 1'b0;
      case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD, ALU_SUB: begin
            result   = sum;
            overflow = c_msb ^ c_out;
         end
         ALU_NOR: result = a_eff & b_eff;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with registered result, valid/ready on both sides and a
// WIDTH-cycle shift-add unsigned multiplier.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   alu_seq_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               overflow_q;
   logic               out_valid_q;
   logic               in_ready;
   logic               accept;
   logic [WIDTH-1:0]   comb_result;
   logic               comb_overflow;
   logic               comb_set;
   logic [WIDTH-1:0]   single_result;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a        (bus.src1_i),
      .b        (bus.src2_i),
      .ctrl     (bus.ctrl_i),
      .result   (comb_result),
      .overflow (comb_overflow),
      .set      (comb_set)
   );

   always_comb begin
      in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready_i);
      accept        = bus.in_valid_i && in_ready;
      single_result = (bus.ctrl_i == ALU_SLT) ? WIDTH'(comb_set) : comb_result;
      acc_next      = mplier[0] ? acc + mcand : acc;
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept && bus.ctrl_i == ALU_MULU) begin
                  state       <= MUL;
                  cnt         <= '0;
                  acc         <= '0;
                  mcand       <= {{WIDTH{1'b0}}, bus.src1_i};
                  mplier      <= bus.src2_i;
                  out_valid_q <= 1'b0;
               end else if (accept) begin
                  state       <= DONE;
                  result_q    <= single_result;
                  zero_q      <= (single_result == '0);
                  overflow_q  <= comb_overflow;
                  out_valid_q <= 1'b1;
               end else if (state == DONE && bus.out_ready_i) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state       <= DONE;
                  result_q    <= acc_next[WIDTH-1:0];
                  zero_q      <= (acc_next[WIDTH-1:0] == '0);
                  overflow_q  <= |acc_next[2*WIDTH-1:WIDTH];
                  out_valid_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.zero_o      = zero_q;
   assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH = 32): directed vector table,
// hand-written handshake/reset sequences and random ops against a reference model.
module tb_alu_seq_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   alu_seq_unit_if #(.WIDTH(32)) bus ();

   alu_seq_unit #(.WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model straight from the operation definitions.
   function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
      logic [63:0] p;
      r = '0;
      o = 1'b0;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
         4'b0110: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
         4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: r = ~(a | b);
         4'b0011: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; o = |p[63:32]; end
         default: ;
      endcase
   endfunction

   // Issue one op from an idle/draining unit with out_ready held high and check the response.
   task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo,
                         input int elat);
      int k;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b1;
      bus.ctrl_i     = c;
      bus.src1_i     = a;
      bus.src2_i     = b;
      check({nm, " in_ready"}, 64'(bus.in_ready_o), 64'd1);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      bus.src1_i     = $urandom;
      bus.src2_i     = $urandom;
      bus.ctrl_i     = 4'($urandom);
      k = 1;
      @(negedge clk);
      while (!bus.out_valid_o && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({nm, " latency"},  64'(k), 64'(elat));
      check({nm, " result"},   64'(bus.result_o), 64'(er));
      check({nm, " overflow"}, 64'(bus.overflow_o), 64'(eo));
      check({nm, " zero"},     64'(bus.zero_o), 64'(er == 32'd0));
   endtask

   initial begin
      logic [31:0] er;
      logic        eo;
      logic [3:0]  c;
      int          hits;
      logic [3:0]  codes[7];

      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      bus.src1_i      = '0;
      bus.src2_i      = '0;
      bus.ctrl_i      = '0;

      vecs[0]  = '{"add_ovf",    4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1};
      vecs[1]  = '{"sub_eq",     4'b0110, 32'd5,         32'd5,         32'h0,         1'b0, 1};
      vecs[2]  = '{"slt_minneg", 4'b0111, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1};
      vecs[3]  = '{"slt_maxpos", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1};
      vecs[4]  = '{"slt_eq",     4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1};
      vecs[5]  = '{"mulu_full",  4'b0011, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 33};
      vecs[6]  = '{"mulu_ovf",   4'b0011, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1, 33};
      vecs[7]  = '{"illegal_f",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1'b0, 1};
      vecs[8]  = '{"and",        4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
      vecs[9]  = '{"or",         4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1};
      vecs[10] = '{"illegal_4",  4'b0100, 32'd5,         32'd3,         32'h0,         1'b0, 1};
      vecs[11] = '{"nor",        4'b1100, 32'hFF00_FF00, 32'h00F0_00F0, 32'h000F_000F, 1'b0, 1};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst result",    64'(bus.result_o),    64'd0);
      check("rst zero",      64'(bus.zero_o),      64'd1);
      check("rst overflow",  64'(bus.overflow_o),  64'd0);
      check("rst out_valid", 64'(bus.out_valid_o), 64'd0);
      check("rst in_ready",  64'(bus.in_ready_o),  64'd1);

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat);

      // Back-to-back single-cycle ops with out_ready held high
      @(posedge clk); #1;
      bus.in_valid_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd1; bus.src2_i = 32'd2;
      @(posedge clk); #1;
      bus.ctrl_i = 4'b0010; bus.src1_i = 32'd3; bus.src2_i = 32'd4;
      @(negedge clk);
      check("b2b first",    64'(bus.result_o),   64'd3);
      check("b2b in_ready", 64'(bus.in_ready_o), 64'd1);
      @(posedge clk); #1;
      bus.ctrl_i = 4'b0110; bus.src1_i = 32'd10; bus.src2_i = 32'd3;
      @(negedge clk);
      check("b2b second", 64'(bus.result_o), 64'd7);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check("b2b third",     64'(bus.result_o),    64'd7);
      check("b2b third vld", 64'(bus.out_valid_o), 64'd1);
      @(negedge clk);
      check("b2b drained vld", 64'(bus.out_valid_o), 64'd0);
      check("b2b held result", 64'(bus.result_o),    64'd7);

      // Backpressure, with a request held pending while the result is stalled
      @(posedge clk); #1;
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1; bus.ctrl_i = 4'b0000; bus.src1_i = 32'hF0F0; bus.src2_i = 32'hFF00;
      @(posedge clk); #1;
      bus.ctrl_i = 4'b0001; bus.src1_i = 32'hFFFF_FFFF; bus.src2_i = 32'h1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp vld%0d", i),    64'(bus.out_valid_o), 64'd1);
         check($sformatf("bp result%0d", i), 64'(bus.result_o),   64'h0000_F000);
         check($sformatf("bp ready%0d", i),  64'(bus.in_ready_o), 64'd0);
         @(posedge clk);
      end
      #1;
      bus.out_ready_i = 1'b1;
      bus.ctrl_i = 4'b1100; bus.src1_i = 32'd0; bus.src2_i = 32'd0;
      @(negedge clk);
      check("bp release ready",  64'(bus.in_ready_o), 64'd1);
      check("bp release result", 64'(bus.result_o),   64'h0000_F000);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check("bp nor vld",    64'(bus.out_valid_o), 64'd1);
      check("bp nor result", 64'(bus.result_o),    64'hFFFF_FFFF);
      check("bp nor zero",   64'(bus.zero_o),      64'd0);

      // Reset in the middle of a multiply
      @(posedge clk); #1;
      bus.in_valid_i = 1'b1; bus.ctrl_i = 4'b0011; bus.src1_i = 32'd7; bus.src2_i = 32'd9;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      hits = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 2) check("mul busy ready", 64'(bus.in_ready_o), 64'd0);
         if (bus.out_valid_o) hits++;
         @(posedge clk);
      end
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid-mul rst result", 64'(bus.result_o),   64'd0);
      check("mid-mul rst zero",   64'(bus.zero_o),     64'd1);
      check("mid-mul rst ready",  64'(bus.in_ready_o), 64'd1);
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid_o) hits++;
         @(negedge clk);
      end
      check("mid-mul no valid", 64'(hits), 64'd0);

      // Random ops against the reference model
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         c = (($urandom % 8) == 0) ? 4'($urandom) : codes[$urandom % 7];
         a = $urandom;
         b = $urandom;
         if (($urandom % 4) == 0) b = 32'($urandom % 5) - 32'd2;
         model(c, a, b, er, eo);
         run_op($sformatf("rnd%0d c=%b", i, c), c, a, b, er, eo, (c == 4'b0011) ? 33 : 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
